// File: rtl/dual_port_sync_ram.sv
// dual_port_sync_ram: two-port synchronous RAM with a zeroing sweep controller and a registered address-collision flag.
module dual_port_sync_ram #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en_a,
  input  logic              en_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_a,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_a,
  output logic [DATA_W-1:0] dout_b,
  output logic              busy,
  output logic              collision
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {S_CLEAR, S_READY} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_ready;
  logic              w_wr_a;
  logic              w_wr_b;
  assign w_ready = r_state == S_READY;
  assign w_wr_a  = w_ready && en_a && we_a;
  assign w_wr_b  = w_ready && en_b && we_b;
  assign busy    = !w_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else if (!w_ready) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      if (&r_clr_cnt) r_state <= S_READY;
    end else if (clr) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end
  end
  // Port A is written last so it wins a same-address write race.
  always_ff @(posedge clk) begin
    if (!w_ready) r_mem[r_clr_cnt] <= '0;
    else begin
      if (w_wr_b) r_mem[addr_b] <= din_b;
      if (w_wr_a) r_mem[addr_a] <= din_a;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a    <= '0;
      dout_b    <= '0;
      collision <= 1'b0;
    end else begin
      collision <= w_ready && en_a && en_b && addr_a == addr_b && (we_a || we_b);
      if (w_ready && en_a) dout_a <= (RDW_MODE != 0 && we_a) ? din_a : r_mem[addr_a];
      if (w_ready && en_b) dout_b <= (RDW_MODE != 0 && we_b) ? din_b : r_mem[addr_b];
    end
  end
endmodule
